// File: rtl/sprite_mem_arbiter.sv
`timescale 1ns/1ps
// sprite_mem_arbiter
// Shares one single-port sprite RAM between the video line-fetch engine
// (row bursts of 1..16 words) and an Avalon host (single-word accesses).
// Arbitration happens only in IDLE, and a round-robin bit breaks ties.
// Every transaction returns to IDLE, so the two requesters never overlap.
module sprite_mem_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    // host (Avalon slave side)
    input  logic [ADDR_W-1:0] host_address,
    input  logic              host_read,
    input  logic              host_write,
    input  logic [DATA_W-1:0] host_writedata,
    input  logic [1:0]        host_byteenable,
    output logic [DATA_W-1:0] host_readdata,
    output logic              host_waitrequest,
    // line-fetch engine
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_base,
    input  logic [LEN_W-1:0]  fetch_len,
    output logic              fetch_ack,
    output logic              fetch_busy,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    output logic [3:0]        fetch_index,
    output logic              fetch_done,
    // sprite RAM
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic [1:0]        mem_byteenable,
    input  logic [DATA_W-1:0] mem_readdata
);

    // A length field of zero encodes the maximum burst.
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << (LEN_W - 1));

    typedef enum logic [2:0] {
        IDLE,
        BURST,
        BDRAIN,
        HWRITE,
        HREAD,
        HRESP
    } state_t;

    typedef enum logic {
        LG_HOST,
        LG_FETCH
    } grant_t;

    state_t              state_reg, state_next;
    grant_t              last_grant_reg, last_grant_next;

    logic [ADDR_W-1:0]   base_reg;
    logic [LEN_W-1:0]    len_reg;
    logic [LEN_W-1:0]    cnt_reg;
    logic [ADDR_W-1:0]   haddr_reg;
    logic [DATA_W-1:0]   hwdata_reg;
    logic [1:0]          hbe_reg;
    logic                valid_reg;
    logic [3:0]          index_reg;

    logic                fetch_pend;
    logic                host_pend;
    logic                grant_fetch;
    logic                grant_host;
    logic                host_complete;

    assign fetch_pend = fetch_req;
    assign host_pend  = host_read | host_write;

    // State and round-robin registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= LG_HOST;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
        end
    end

    // Next-state, grant decision and RAM-side controls.
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        grant_fetch     = 1'b0;
        grant_host      = 1'b0;
        host_complete   = 1'b0;
        mem_address     = '0;
        mem_chipselect  = 1'b0;
        mem_write       = 1'b0;
        mem_writedata   = '0;
        mem_byteenable  = 2'b00;
        case (state_reg)
            IDLE: begin
                // Fetch wins when alone, or on a tie when the host went last.
                if (fetch_pend && (!host_pend || last_grant_reg == LG_HOST)) begin
                    grant_fetch     = 1'b1;
                    last_grant_next = LG_FETCH;
                    state_next      = BURST;
                end else if (host_pend) begin
                    grant_host      = 1'b1;
                    last_grant_next = LG_HOST;
                    state_next      = host_write ? HWRITE : HREAD;
                end
            end
            BURST: begin
                // Address arithmetic is ADDR_W wide, so it wraps at the top of RAM.
                mem_chipselect = 1'b1;
                mem_byteenable = 2'b11;
                mem_address    = base_reg + ADDR_W'(cnt_reg);
                if (cnt_reg == len_reg - LEN_W'(1)) begin
                    state_next = BDRAIN;
                end
            end
            BDRAIN: begin
                state_next = IDLE;
            end
            HWRITE: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_address    = haddr_reg;
                mem_writedata  = hwdata_reg;
                mem_byteenable = hbe_reg;
                host_complete  = 1'b1;
                state_next     = IDLE;
            end
            HREAD: begin
                mem_chipselect = 1'b1;
                mem_byteenable = 2'b11;
                mem_address    = haddr_reg;
                state_next     = HRESP;
            end
            HRESP: begin
                host_complete = 1'b1;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Burst/host operand capture, burst counter and the one-cycle fetch pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_reg   <= '0;
            len_reg    <= '0;
            cnt_reg    <= '0;
            haddr_reg  <= '0;
            hwdata_reg <= '0;
            hbe_reg    <= 2'b00;
            valid_reg  <= 1'b0;
            index_reg  <= 4'd0;
        end else begin
            if (grant_fetch) begin
                base_reg <= fetch_base;
                len_reg  <= (fetch_len == '0) ? MAX_LEN : fetch_len;
                cnt_reg  <= '0;
            end else if (state_reg == BURST) begin
                cnt_reg <= cnt_reg + LEN_W'(1);
            end
            if (grant_host) begin
                haddr_reg  <= host_address;
                hwdata_reg <= host_writedata;
                hbe_reg    <= host_byteenable;
            end
            // RAM data lags its address by one cycle; track which word it is.
            valid_reg <= (state_reg == BURST);
            index_reg <= cnt_reg[3:0];
        end
    end

    // The accept pulse is combinational from IDLE, so it is masked while reset is held.
    assign fetch_ack        = grant_fetch & ~reset;
    assign fetch_busy       = (state_reg == BURST) || (state_reg == BDRAIN);
    assign fetch_valid      = valid_reg;
    assign fetch_index      = valid_reg ? index_reg : 4'd0;
    assign fetch_data       = valid_reg ? mem_readdata : '0;
    assign fetch_done       = (state_reg == BDRAIN);

    assign host_readdata    = (state_reg == HRESP) ? mem_readdata : '0;
    assign host_waitrequest = host_pend & ~host_complete;

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
`timescale 1ns/1ps
// Bench for sprite_mem_arbiter: RAM model, randomized drivers for both
// requesters, and a scoreboard fed at issue time and drained by a monitor.
module tb_sprite_mem_arbiter;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 5;
    localparam byte F_EV  = 8'h46;
    localparam byte H_EV  = 8'h48;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] host_address = '0;
    logic              host_read = 1'b0;
    logic              host_write = 1'b0;
    logic [DATA_W-1:0] host_writedata = '0;
    logic [1:0]        host_byteenable = 2'b00;
    logic [DATA_W-1:0] host_readdata;
    logic              host_waitrequest;
    logic              fetch_req = 1'b0;
    logic [ADDR_W-1:0] fetch_base = '0;
    logic [LEN_W-1:0]  fetch_len = '0;
    logic              fetch_ack;
    logic              fetch_busy;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_valid;
    logic [3:0]        fetch_index;
    logic              fetch_done;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic [1:0]        mem_byteenable;
    logic [DATA_W-1:0] mem_readdata;

    always #5 clk = ~clk;

    sprite_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset),
        .host_address(host_address), .host_read(host_read), .host_write(host_write),
        .host_writedata(host_writedata), .host_byteenable(host_byteenable),
        .host_readdata(host_readdata), .host_waitrequest(host_waitrequest),
        .fetch_req(fetch_req), .fetch_base(fetch_base), .fetch_len(fetch_len),
        .fetch_ack(fetch_ack), .fetch_busy(fetch_busy), .fetch_data(fetch_data),
        .fetch_valid(fetch_valid), .fetch_index(fetch_index), .fetch_done(fetch_done),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_readdata(mem_readdata)
    );

    // ---------------- sprite RAM (registered read, byte-lane writes) ----------------
    logic [15:0] ram [0:511];
    logic [15:0] ram_q;
    logic        ld_en = 1'b0;
    logic [8:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;

    always @(posedge clk) begin
        if (ld_en) begin
            ram[ld_addr] <= ld_data;
        end else if (mem_chipselect) begin
            if (mem_write && mem_byteenable[0]) ram[mem_address][7:0]  <= mem_writedata[7:0];
            if (mem_write && mem_byteenable[1]) ram[mem_address][15:8] <= mem_writedata[15:8];
            ram_q <= ram[mem_address];
        end
    end
    assign mem_readdata = ram_q;

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic [15:0] data;
        logic [3:0]  idx;
        logic        done;
        logic [8:0]  addr;
    } fexp_t;

    logic [15:0] ref_mem [0:511];
    fexp_t       fetch_exp[$];
    logic [15:0] host_exp[$];
    byte         order_log[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int done_cyc = 0;
    int host_cyc = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    logic [8:0] prev_addr = '0;
    logic       prev_cs = 1'b0;

    always @(negedge clk) begin
        fexp_t e;
        if (reset) begin
            prev_addr <= '0;
            prev_cs   <= 1'b0;
        end else begin
            if (fetch_ack) order_log.push_back(F_EV);
            if (fetch_valid) begin
                if (fetch_exp.size() == 0) begin
                    chk("fetch_unexpected_word", 32'(fetch_index), 32'hFFFF_FFFF);
                end else begin
                    e = fetch_exp.pop_front();
                    chk("fetch_data", 32'(fetch_data), 32'(e.data));
                    chk("fetch_index", 32'(fetch_index), 32'(e.idx));
                    chk("fetch_done", 32'(fetch_done), 32'(e.done));
                    chk("burst_mem_address", 32'(prev_addr), 32'(e.addr));
                    chk("burst_chipselect", 32'(prev_cs), 32'd1);
                    chk("fetch_busy", 32'(fetch_busy), 32'd1);
                end
            end
            if (fetch_done) begin
                chk("done_with_valid", 32'(fetch_valid), 32'd1);
                done_cnt++;
                done_cyc = cyc;
                $display("burst done: count=%0d cycle=%0d", done_cnt, cyc);
            end
            if ((host_read || host_write) && !host_waitrequest) begin
                host_cyc = cyc;
                order_log.push_back(H_EV);
                if (host_read) begin
                    if (host_exp.size() == 0) chk("host_unexpected_read", 32'(host_readdata), 32'hFFFF_FFFF);
                    else chk("host_readdata", 32'(host_readdata), 32'(host_exp.pop_front()));
                    $display("host rd addr=%03h data=%04h cycle=%0d", host_address, host_readdata, cyc);
                end else begin
                    $display("host wr addr=%03h data=%04h be=%b cycle=%0d", host_address, host_writedata, host_byteenable, cyc);
                end
            end
            prev_addr <= mem_address;
            prev_cs   <= mem_chipselect;
        end
    end

    // ---------------- drivers ----------------
    task automatic load_word(input logic [8:0] a, input logic [15:0] v);
        ld_en = 1'b1; ld_addr = a; ld_data = v;
        ref_mem[a] = v;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic host_access(input logic wr, input logic [8:0] a, input logic [15:0] d,
                               input logic [1:0] be, input bit chk_lat);
        int n;
        @(posedge clk); #1;
        host_address = a; host_writedata = d; host_byteenable = be;
        if (wr) begin
            if (be[0]) ref_mem[a][7:0]  = d[7:0];
            if (be[1]) ref_mem[a][15:8] = d[15:8];
            host_write = 1'b1;
        end else begin
            host_exp.push_back(ref_mem[a]);
            host_read = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (host_waitrequest && n < 300);
        if (host_waitrequest) chk("host_timeout", 32'd1, 32'd0);
        if (chk_lat) chk(wr ? "write_latency" : "read_latency", 32'(n), wr ? 32'd2 : 32'd3);
        if (wr) begin
            chk("mem_write_pulse", 32'({mem_chipselect, mem_write}), 32'd3);
            chk("mem_write_addr", 32'(mem_address), 32'(a));
            chk("mem_write_be", 32'(mem_byteenable), 32'(be));
            chk("mem_write_data", 32'(mem_writedata), 32'(d));
        end
        @(posedge clk); #1;
        host_read = 1'b0; host_write = 1'b0;
    endtask

    task automatic fetch_issue(input logic [8:0] b, input logic [4:0] l);
        int n;
        int len;
        @(posedge clk); #1;
        fetch_base = b; fetch_len = l; fetch_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fetch_ack && n < 500);
        if (!fetch_ack) begin
            chk("fetch_ack_timeout", 32'd1, 32'd0);
        end else begin
            len = (l == 5'd0) ? 16 : int'(l);
            for (int k = 0; k < len; k++) begin
                fexp_t e;
                e.addr = b + 9'(k);
                e.data = ref_mem[e.addr];
                e.idx  = 4'(k);
                e.done = (k == len - 1);
                fetch_exp.push_back(e);
            end
            exp_done++;
        end
        @(posedge clk); #1;
        fetch_req = 1'b0;
        fetch_base = 9'($urandom);
        fetch_len  = 5'($urandom);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((fetch_exp.size() != 0 || host_exp.size() != 0 || fetch_busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("drain_timeout", 32'd1, 32'd0);
        repeat (2) @(posedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        byte exp_ord [4];
        int  n;
        exp_ord = '{F_EV, H_EV, F_EV, H_EV};

        for (int i = 0; i < 512; i++) load_word(9'(i), 16'($urandom));

        // Both requesters held from reset: fetch first, then alternate.
        fork
            begin
                fetch_issue(9'h010, 5'd2);
                fetch_issue(9'h020, 5'd2);
            end
            begin
                host_access(1'b0, 9'h055, 16'h0, 2'b00, 1'b0);
                host_access(1'b0, 9'h056, 16'h0, 2'b00, 1'b0);
            end
            begin
                repeat (2) @(negedge clk);
                chk("rst_waitrequest", 32'(host_waitrequest), 32'd1);
                chk("rst_fetch_ack", 32'(fetch_ack), 32'd0);
                chk("rst_chipselect", 32'(mem_chipselect), 32'd0);
                chk("rst_fetch_busy", 32'(fetch_busy), 32'd0);
                chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
                chk("rst_host_readdata", 32'(host_readdata), 32'd0);
                @(posedge clk); #2;
                reset = 1'b0;
            end
        join
        wait_drain();
        chk("grant_order_len", 32'(order_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < order_log.size()) chk("grant_order", 32'(order_log[i]), 32'(exp_ord[i]));
        end

        // Burst wrapping past the top of RAM.
        load_word(9'h1FE, 16'hA0A1);
        load_word(9'h1FF, 16'hB0B1);
        load_word(9'h000, 16'hC0C1);
        load_word(9'h001, 16'hD0D1);
        fetch_issue(9'h1FE, 5'd4);
        wait_drain();

        // Length zero means a full 16-word burst.
        fetch_issue(9'($urandom), 5'd0);
        wait_drain();

        // Host write/read timing and byte lanes.
        host_access(1'b1, 9'h123, 16'hBEEF, 2'b11, 1'b1);
        host_access(1'b0, 9'h123, 16'h0, 2'b00, 1'b1);
        host_access(1'b1, 9'h123, 16'h5500, 2'b10, 1'b1);
        host_access(1'b0, 9'h123, 16'h0, 2'b00, 1'b1);

        // Host read arriving mid-burst is held off until the burst has drained.
        fetch_issue(9'h0F0, 5'd0);
        repeat (3) @(posedge clk);
        host_access(1'b0, 9'h123, 16'h0, 2'b00, 1'b0);
        chk("host_after_bdrain", 32'(host_cyc - done_cyc), 32'd3);
        wait_drain();

        // Reset while word 5 is being addressed abandons the burst.
        fetch_issue(9'h100, 5'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(fetch_valid && fetch_index == 4'd4) && n < 100);
        chk("reach_word5", 32'(fetch_index), 32'd4);
        #1 reset = 1'b1;
        #1;
        chk("abort_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("abort_fetch_busy", 32'(fetch_busy), 32'd0);
        chk("abort_fetch_done", 32'(fetch_done), 32'd0);
        chk("abort_fetch_index", 32'(fetch_index), 32'd0);
        chk("abort_fetch_data", 32'(fetch_data), 32'd0);
        chk("abort_chipselect", 32'(mem_chipselect), 32'd0);
        fetch_exp.delete();
        exp_done--;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        fetch_issue(9'h1F8, 5'd5);
        wait_drain();

        // Random host-only traffic with exact latency checks.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1)
                host_access(1'b1, 9'($urandom), 16'($urandom), 2'($urandom_range(1, 3)), 1'b1);
            else
                host_access(1'b0, 9'($urandom), 16'h0, 2'b00, 1'b1);
        end
        wait_drain();

        // Random concurrent bursts and host reads.
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    fetch_issue(9'($urandom), 5'($urandom_range(0, 16)));
                end
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    repeat ($urandom_range(0, 4)) @(posedge clk);
                    host_access(1'b0, 9'($urandom), 16'h0, 2'b00, 1'b0);
                end
            end
        join
        wait_drain();

        chk("done_count", 32'(done_cnt), 32'(exp_done));
        chk("fetch_queue_empty", 32'(fetch_exp.size()), 32'd0);
        chk("host_queue_empty", 32'(host_exp.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sprite_mem_arbiter.md
Name: sprite_mem_arbiter

Overview:
- Shares one single-port 512x16 sprite on-chip memory between two requesters.
- The video line-fetch engine issues row bursts of 1..16 words; the HPS/Avalon host issues single-word reads and writes.
- Sits between the sprite RAM's Avalon slave port and both masters. Owns all memory addressing and write enables, plus the grant policy.

Parameters:
ADDR_W, 9, memory word-address width (512 words)
DATA_W, 16, memory word width
LEN_W, 5, burst length field width; max burst 16 words

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
host_address  in  ADDR_W  host word address
host_read  in  1  host read request, held until waitrequest low
host_write  in  1  host write request, held until waitrequest low
host_writedata  in  DATA_W  host write data
host_byteenable  in  2  host byte lanes (writes only)
host_readdata  out  DATA_W  read data, valid when read and waitrequest low
host_waitrequest  out  1  Avalon stall
fetch_req  in  1  burst request level, held until fetch_ack
fetch_base  in  ADDR_W  burst start address
fetch_len  in  LEN_W  burst length; 0 means 16
fetch_ack  out  1  one-cycle accept pulse
fetch_busy  out  1  burst in progress
fetch_data  out  DATA_W  burst word
fetch_valid  out  1  fetch_data valid
fetch_index  out  4  word index within burst
fetch_done  out  1  pulse with last valid word
mem_address  out  ADDR_W  to RAM
mem_chipselect  out  1  to RAM
mem_write  out  1  to RAM
mem_writedata  out  DATA_W  to RAM
mem_byteenable  out  2  to RAM
mem_readdata  in  DATA_W  RAM q; valid one cycle after address

Behaviour:
- Reset (async) forces state IDLE, last_grant=HOST, counters 0. All outputs are 0 except host_waitrequest.
- host_waitrequest is combinational: (host_read|host_write) & ~host_complete. During reset it is therefore high whenever the host is requesting.
- Reset mid-burst or mid-host-access abandons the operation: no fetch_done, no host completion.
- States: IDLE, BURST, BDRAIN, HWRITE, HREAD, HRESP.
- IDLE: mem_chipselect=0. The block arbitrates only in IDLE.
  - Fetch pending alone: grant fetch.
  - Host pending alone: grant host.
  - Both pending: grant the side not recorded in last_grant, then update last_grant.
  - Fetch grant: fetch_ack=1 this cycle; latch base, len (0->16), cnt=0; next state BURST.
  - Host grant: write -> HWRITE; read -> HREAD. host_address, writedata and byteenable are latched.
- HWRITE (1 cycle): mem_chipselect=1, mem_write=1, address/data/byteenable from the latched values. host_complete=1. Next state IDLE.
- HREAD: mem_chipselect=1, mem_byteenable=2'b11. Next state HRESP.
- HRESP: host_readdata=mem_readdata (combinational), host_complete=1. Next state IDLE.
- Host timing: a read completes on the 3rd cycle after the request is seen in IDLE; a write completes on the 2nd.
- BURST: one word per cycle, mem_address=(base+cnt) mod 512 (wraps 511->0), mem_chipselect=1.
  - cnt increments each cycle. On issuing word len-1, the next state is BDRAIN.
- Fetch output pipeline: fetch_valid, fetch_index and fetch_data=mem_readdata are asserted the cycle after each address, so word k appears in cycle k+1 after BURST entry.
- BDRAIN: presents the last word; fetch_done=1 with it. Next state IDLE.
- fetch_busy=1 in BURST and BDRAIN.
- Host requests arriving during a burst stall; they are served at the next IDLE, subject to round-robin.
- Back-to-back: each transaction returns to IDLE for one arbitration cycle; no overlap between requesters.
- fetch_base and fetch_len changes after fetch_ack have no effect.

Test Plan:
- Burst wrap: base=0x1FE, len=4, RAM[0x1FE,0x1FF,0,1]=A,B,C,D -> fetch_valid 4 consecutive cycles with data A,B,C,D, index 0..3; fetch_done with D; mem_address 1FE,1FF,000,001.
- Host write/read: write 0x0123=0xBEEF with byteenable 2'b11, then read 0x0123 -> write waitrequest low on 2nd cycle with mem_write pulse; read returns 0xBEEF on 3rd cycle.
- Byteenable: write 0x0123=0x5500 with byteenable 2'b10 over 0xBEEF -> readback 0x55EF.
- Simultaneous requests from reset, held: fetch (len=2) granted first, then host; repeated -> grants alternate fetch, host, fetch.
- len=0 -> exactly 16 valid words, index 0..15, single fetch_done.
- Host read asserted mid-burst -> waitrequest held high until the burst's BDRAIN passes, then completes with correct data.
- Reset asserted during BURST word 5 -> all fetch outputs 0 immediately; no fetch_done; next request starts cleanly at index 0.
